// File: rtl/orv64_dmem_req_ctrl.sv
// orv64_dmem_req_ctrl: core data-memory request sequencer with alignment check, lane steering,
// load extension and bounded miss retry.
module orv64_dmem_req_ctrl #(
   parameter int unsigned MAX_RETRY = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [63:0] req_addr,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic [1:0]  resp_err,
   output logic [63:0] data_raddr,
   output logic        data_re,
   input  logic        data_rmiss,
   input  logic [63:0] data_rdata,
   output logic [63:0] data_waddr,
   output logic [63:0] data_wdata,
   output logic [7:0]  data_wmask,
   output logic        data_we,
   input  logic        data_wmiss
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   localparam logic [7:0] MAX_R = 8'(MAX_RETRY);
   state_t      state_q, state_d;
   logic [63:0] addr_q, wdata_q, rdata_q, rdata_d, ld_sh, ld_ext;
   logic [7:0]  retry_q, retry_d, size_mask;
   logic [1:0]  size_q, err_q, err_d;
   logic        we_q, uns_q, misal, miss, timeout, sx;
   assign misal = (req_size == 2'd1 && req_addr[0]) ||
                  (req_size == 2'd2 && |req_addr[1:0]) ||
                  (req_size == 2'd3 && |req_addr[2:0]);
   // only the miss line of the direction actually issued is meaningful
   assign miss    = we_q ? data_wmiss : data_rmiss;
   assign timeout = miss && retry_q == MAX_R;
   assign sx      = ~uns_q;
   assign ld_sh   = data_rdata >> {addr_q[2:0], 3'b000};
   assign ld_ext  = size_q == 2'd0 ? {{56{sx & ld_sh[7]}}, ld_sh[7:0]} :
                    size_q == 2'd1 ? {{48{sx & ld_sh[15]}}, ld_sh[15:0]} :
                    size_q == 2'd2 ? {{32{sx & ld_sh[31]}}, ld_sh[31:0]} : ld_sh;
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = req_valid ? (misal ? RESP : ISSUE) : IDLE;
         ISSUE:   state_d = WAIT;
         WAIT:    state_d = (miss && !timeout) ? ISSUE : RESP;
         default: state_d = resp_ready ? IDLE : RESP;
      endcase
   end
   always_comb begin
      size_mask  = size_q == 2'd0 ? 8'h01 : size_q == 2'd1 ? 8'h03 : size_q == 2'd2 ? 8'h0F : 8'hFF;
      req_ready  = state_q == IDLE;
      resp_valid = state_q == RESP;
      resp_rdata = rdata_q;
      resp_err   = err_q;
      data_raddr = {addr_q[63:3], 3'b000};
      data_waddr = {addr_q[63:3], 3'b000};
      data_re    = state_q == ISSUE && !we_q && !rst;
      data_we    = state_q == ISSUE && we_q && !rst;
      data_wmask = we_q ? size_mask << addr_q[2:0] : '0;
      data_wdata = we_q ? wdata_q << {addr_q[2:0], 3'b000} : '0;
   end
   always_comb begin
      retry_d = retry_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      if (state_q == IDLE && req_valid) begin
         retry_d = '0;
         err_d   = misal ? 2'd1 : 2'd0;
         rdata_d = '0;
      end else if (state_q == WAIT) begin
         retry_d = (miss && !timeout) ? retry_q + 8'd1 : retry_q;
         err_d   = timeout ? 2'd2 : 2'd0;
         rdata_d = (miss || we_q) ? '0 : ld_ext;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         retry_q <= '0;
         err_q   <= '0;
         rdata_q <= '0;
      end else begin
         if (state_q == IDLE && req_valid && !misal) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
         end
         retry_q <= retry_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end
endmodule

// File: tb/tb_orv64_dmem_req_ctrl.sv
// tb_orv64_dmem_req_ctrl: directed scoreboard bench; one instance at default retry limit, one at MAX_RETRY=2.
module tb_orv64_dmem_req_ctrl;
   logic        clk = 1'b0, rst = 1'b1;
   logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b0;
   logic [63:0] req_addr = '0, req_wdata = '0, data_rdata = '0;
   logic [1:0]  req_size = '0;
   logic        data_rmiss = 1'b0, data_wmiss = 1'b0, use2 = 1'b0;
   logic        a_ready, a_rv, a_re, a_we, b_ready, b_rv, b_re, b_we;
   logic [63:0] a_rdata, a_raddr, a_waddr, a_wdata, b_rdata, b_raddr, b_waddr, b_wdata;
   logic [1:0]  a_err, b_err;
   logic [7:0]  a_wmask, b_wmask;
   logic        o_req_ready, o_resp_valid, o_re, o_we;
   logic [63:0] o_rdata, o_raddr, o_waddr, o_wdata;
   logic [1:0]  o_err;
   logic [7:0]  o_wmask;
   logic [65:0] sb[$];
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   orv64_dmem_req_ctrl u_dut_a (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(a_ready), .req_addr(req_addr),
      .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
      .resp_valid(a_rv), .resp_ready(resp_ready), .resp_rdata(a_rdata), .resp_err(a_err),
      .data_raddr(a_raddr), .data_re(a_re), .data_rmiss(data_rmiss), .data_rdata(data_rdata),
      .data_waddr(a_waddr), .data_wdata(a_wdata), .data_wmask(a_wmask), .data_we(a_we),
      .data_wmiss(data_wmiss));

   orv64_dmem_req_ctrl #(.MAX_RETRY(2)) u_dut_b (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_ready), .req_addr(req_addr),
      .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
      .resp_valid(b_rv), .resp_ready(resp_ready), .resp_rdata(b_rdata), .resp_err(b_err),
      .data_raddr(b_raddr), .data_re(b_re), .data_rmiss(data_rmiss), .data_rdata(data_rdata),
      .data_waddr(b_waddr), .data_wdata(b_wdata), .data_wmask(b_wmask), .data_we(b_we),
      .data_wmiss(data_wmiss));

   assign o_req_ready  = use2 ? b_ready : a_ready;
   assign o_resp_valid = use2 ? b_rv    : a_rv;
   assign o_re         = use2 ? b_re    : a_re;
   assign o_we         = use2 ? b_we    : a_we;
   assign o_rdata      = use2 ? b_rdata : a_rdata;
   assign o_err        = use2 ? b_err   : a_err;
   assign o_raddr      = use2 ? b_raddr : a_raddr;
   assign o_waddr      = use2 ? b_waddr : a_waddr;
   assign o_wdata      = use2 ? b_wdata : a_wdata;
   assign o_wmask      = use2 ? b_wmask : a_wmask;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drives one request, acts as the memory (miss for the first nmiss responses),
   // and checks strobes, latency and the scoreboarded response.
   task automatic access(input string tag, input logic [63:0] addr, input logic we,
                         input logic [1:0] size, input logic uns, input logic [63:0] wdata,
                         input logic [63:0] mem, input int nmiss, input logic [63:0] exp_rd,
                         input logic [1:0] exp_err, input int exp_pulses, input int exp_lat,
                         input logic [63:0] exp_wd, input logic [7:0] exp_mask, input int hold);
      int pulses = 0, misses = 0, holdcnt = 0;
      logic prev = 1'b0, seen = 1'b0, done = 1'b0, m;
      logic [65:0] e = '0;
      sb.push_back({exp_err, exp_rd});
      @(negedge clk);
      chk({tag, "_ready"}, o_req_ready, 1);
      req_valid = 1'b1; req_addr = addr; req_we = we; req_size = size;
      req_unsigned = uns; req_wdata = wdata; resp_ready = 1'b0;
      for (int c = 1; c <= 60 && !done; c++) begin
         @(negedge clk);
         req_valid = 1'b0;
         m = prev && (misses < nmiss);
         if (prev) misses++;
         data_rmiss = we ? 1'b1 : (prev ? m : 1'b1);
         data_wmiss = we ? (prev ? m : 1'b1) : 1'b1;
         data_rdata = prev ? mem : '1;
         if (o_re || o_we) begin
            pulses++;
            if (pulses == 1) chk({tag, "_strobe_cyc"}, c, 1);
            chk({tag, "_dir"}, {o_re, o_we}, we ? 2'b01 : 2'b10);
            chk({tag, "_addr"}, we ? o_waddr : o_raddr, {addr[63:3], 3'b000});
            if (we) begin
               chk({tag, "_wmask"}, o_wmask, exp_mask);
               chk({tag, "_wdata"}, o_wdata, exp_wd);
            end
         end
         prev = o_re || o_we;
         if (o_resp_valid) begin
            if (!seen) begin
               chk({tag, "_lat"}, c, exp_lat);
               e = sb.pop_front();
               seen = 1'b1;
            end
            chk({tag, "_rdata"}, o_rdata, e[63:0]);
            chk({tag, "_err"}, o_err, e[65:64]);
            if (holdcnt == hold) begin
               resp_ready = 1'b1;
               done = 1'b1;
            end
            holdcnt++;
         end
      end
      chk({tag, "_done"}, done, 1);
      @(negedge clk);
      resp_ready = 1'b0;
      chk({tag, "_pulses"}, pulses, exp_pulses);
      chk({tag, "_back_idle"}, {o_resp_valid, o_req_ready}, 2'b01);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_ready", o_req_ready, 1);
      chk("rst_resp_valid", o_resp_valid, 0);
      chk("rst_strobes", {o_re, o_we}, 0);
      chk("rst_raddr", o_raddr, 0);
      chk("rst_waddr", o_waddr, 0);
      chk("rst_wdata", o_wdata, 0);
      chk("rst_wmask", o_wmask, 0);
      chk("rst_rdata", o_rdata, 0);
      chk("rst_err", o_err, 0);
      access("ld_h_s", 64'h1006, 0, 1, 0, 0, 64'hABCD_0000_0000_0000, 0,
             64'hFFFF_FFFF_FFFF_ABCD, 0, 1, 3, 0, 0, 0);
      access("ld_h_u", 64'h1006, 0, 1, 1, 0, 64'hABCD_0000_0000_0000, 0,
             64'h0000_0000_0000_ABCD, 0, 1, 3, 0, 0, 0);
      access("ld_b_u", 64'h3F05, 0, 0, 1, 0, 64'h0000_9A00_0000_0000, 0,
             64'h0000_0000_0000_009A, 0, 1, 3, 0, 0, 0);
      access("ld_b_s", 64'h3F05, 0, 0, 0, 0, 64'h0000_9A00_0000_0000, 0,
             64'hFFFF_FFFF_FFFF_FF9A, 0, 1, 3, 0, 0, 0);
      access("ld_w_s", 64'h0010, 0, 2, 0, 0, 64'h0000_0000_8765_4321, 0,
             64'hFFFF_FFFF_8765_4321, 0, 1, 3, 0, 0, 0);
      access("ld_w_u", 64'h0014, 0, 2, 1, 0, 64'h8765_4321_0000_0000, 0,
             64'h0000_0000_8765_4321, 0, 1, 3, 0, 0, 0);
      access("st_w", 64'h2004, 1, 2, 0, 64'h1122_3344, 0, 0,
             0, 0, 1, 3, 64'h1122_3344_0000_0000, 8'hF0, 0);
      access("st_b", 64'h0007, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFAB, 0, 0,
             0, 0, 1, 3, 64'hAB00_0000_0000_0000, 8'h80, 0);
      access("st_h", 64'h000A, 1, 1, 0, 64'h0000_0000_0000_BEEF, 0, 0,
             0, 0, 1, 3, 64'h0000_0000_BEEF_0000, 8'h0C, 0);
      access("st_d", 64'h0008, 1, 3, 0, 64'h0102_0304_0506_0708, 0, 0,
             0, 0, 1, 3, 64'h0102_0304_0506_0708, 8'hFF, 0);
      access("mis_w", 64'h4002, 0, 2, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
      access("mis_h", 64'h4001, 1, 1, 0, 64'h55, 0, 0, 0, 1, 0, 1, 0, 0, 0);
      access("mis_d", 64'h4004, 0, 3, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
      access("ld_retry", 64'h3000, 0, 3, 0, 0, 64'h0123_4567_89AB_CDEF, 3,
             64'h0123_4567_89AB_CDEF, 0, 4, 9, 0, 0, 0);
      use2 = 1'b1;
      access("timeout", 64'h6000, 1, 3, 0, 64'hDEAD, 0, 1000,
             0, 2, 3, 7, 64'hDEAD, 8'hFF, 5);
      use2 = 1'b0;
      // the default-limit instance is still retrying the stuck store: clear it
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      data_rmiss = 1'b1;
      chk("rst2_ready", o_req_ready, 1);
      req_valid = 1'b1; req_addr = 64'h5008; req_we = 1'b0; req_size = 2'd3; req_unsigned = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rst_issue_pre_re", o_re, 1);
      rst = 1'b1;
      #1;
      chk("rst_issue_re", o_re, 0);
      chk("rst_issue_we", o_we, 0);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_issue_ready", o_req_ready, 1);
      chk("rst_issue_resp", o_resp_valid, 0);
      chk("rst_issue_raddr", o_raddr, 0);
      chk("rst_issue_wmask", o_wmask, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("rst_issue_quiet", {o_re, o_we, o_resp_valid}, 0);
      end
      chk("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
